// File: rtl/moving_avg_ctrl.sv
// N-point moving-average controller: sequences an external N-deep delay line,
// keeps a running window sum and hands the floored mean downstream under valid/ready.
module moving_avg_ctrl #(
  parameter int N          = 16,
  parameter int LOG2N      = 4,
  parameter int data_width = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [data_width-1:0] data_in,
  input  logic                         flush,
  output logic                         buf_en,
  output logic                         buf_rst,
  output logic signed [data_width-1:0] buf_data_in,
  input  logic signed [data_width-1:0] buf_data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [data_width-1:0] data_out,
  output logic                         primed,
  output logic [1:0]                   dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both
  // high; valid never depends on ready, and the producer holds data until then.

  localparam int AW = data_width + LOG2N;
  localparam logic [LOG2N:0] FULL = (LOG2N+1)'(N);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT, FLUSH} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic signed [AW-1:0]    r_acc;
  logic [LOG2N:0]          r_fill;
  logic signed [data_width-1:0] r_new;
  logic signed [data_width-1:0] r_old;
  logic signed [data_width-1:0] r_data_out;
  logic                    r_out_valid;
  logic                    r_primed;

  logic                    w_accept;
  logic signed [AW-1:0]    w_new_ext;
  logic signed [AW-1:0]    w_old_ext;
  logic signed [AW-1:0]    w_acc_next;
  logic [LOG2N:0]          w_fill_next;

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    buf_rst      = 1'b0;
    buf_en       = 1'b0;
    buf_data_in  = data_in;
    w_accept     = 1'b0;
    if (flush) begin
      w_next_state = FLUSH;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_next_state = ACCUM;
        ACCUM:   w_next_state = OUT;
        OUT:     if (out_ready) w_next_state = IDLE;
        FLUSH:   w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
    in_ready = rst && (r_state == IDLE) && !flush;
    w_accept = in_ready && in_valid;
    buf_en   = w_accept;
    buf_rst  = !rst || (r_state == FLUSH);
  end

  assign w_new_ext   = {{LOG2N{r_new[data_width-1]}}, r_new};
  assign w_old_ext   = {{LOG2N{r_old[data_width-1]}}, r_old};
  assign w_acc_next  = r_acc + w_new_ext - w_old_ext;
  assign w_fill_next = (r_fill == FULL) ? r_fill : r_fill + (LOG2N+1)'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_fill      <= '0;
      r_new       <= '0;
      r_old       <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_primed    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Oldest tap is captured before the shift so it is the sample leaving the window.
      if (w_accept) begin
        r_new <= data_in;
        r_old <= buf_data_out;
      end
      if (r_state == FLUSH) begin
        r_acc       <= '0;
        r_fill      <= '0;
        r_primed    <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (r_state == ACCUM && !flush) begin
        r_acc       <= w_acc_next;
        r_fill      <= w_fill_next;
        r_primed    <= (w_fill_next == FULL);
        r_data_out  <= w_acc_next[AW-1:LOG2N];
        r_out_valid <= 1'b1;
      end else if (r_state == OUT && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (flush) r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign primed    = r_primed;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_moving_avg_ctrl.sv
// Bench for moving_avg_ctrl: models the delay line, predicts outputs from a
// window-of-samples reference and checks directed plus randomized traffic.
module tb_moving_avg_ctrl;
  localparam int N  = 16;
  localparam int LOG2N = 4;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, buf_en, buf_rst;
  logic out_valid, out_ready, primed;
  logic signed [DW-1:0] data_in, buf_data_in, buf_data_out, data_out;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  moving_avg_ctrl #(.N(N), .LOG2N(LOG2N), .data_width(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .flush(flush), .buf_en(buf_en), .buf_rst(buf_rst),
    .buf_data_in(buf_data_in), .buf_data_out(buf_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .primed(primed), .dbg_state(dbg_state)
  );

  // External delay line
  logic signed [DW-1:0] taps [N];
  always @(posedge clk) begin
    if (buf_rst) begin
      for (int i = 0; i < N; i++) taps[i] <= '0;
    end else if (buf_en) begin
      taps[0] <= buf_data_in;
      for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
    end
  end
  assign buf_data_out = taps[N-1];

  int n_buf_en = 0;
  always @(posedge clk) if (buf_en === 1'b1) n_buf_en <= n_buf_en + 1;

  // Reference model and scoreboard
  longint          win[$];
  logic [DW-1:0]   exp_q[$];
  logic            exp_p_q[$];
  int              fill_cnt = 0;
  int              n_accept = 0;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    win.delete();
    exp_q.delete();
    exp_p_q.delete();
    fill_cnt = 0;
  endtask

  task automatic model_accept(input logic signed [DW-1:0] s);
    longint sum;
    longint avg;
    win.push_back(longint'(s));
    if (win.size() > N) void'(win.pop_front());
    sum = 0;
    foreach (win[i]) sum += win[i];
    if (sum >= 0) avg = sum / N;
    else          avg = -((-sum + N - 1) / N);
    exp_q.push_back(avg[DW-1:0]);
    if (fill_cnt < N) fill_cnt++;
    exp_p_q.push_back(fill_cnt == N);
    n_accept++;
  endtask

  task automatic send_sample(input logic signed [DW-1:0] s);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = s;
      #1;
      if (in_ready) begin
        @(posedge clk);
        model_accept(s);
        done = 1;
        #1 in_valid = 1'b0;
      end
    end
    if (!done) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) ok = 1;
    end
  endtask

  task automatic get_output(input int stall);
    bit ok;
    logic signed [DW-1:0] e;
    logic ep;
    out_ready = 1'b0;
    wait_out_valid(ok);
    e  = exp_q.pop_front();
    ep = exp_p_q.pop_front();
    if (!ok) begin
      check("out_valid_timeout", 0, 1);
    end else begin
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("out_valid_held", out_valid, 1);
      check("data_out", data_out, e);
      check("primed", primed, ep);
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    check("rst_out_valid", out_valid, 0);
    check("rst_primed", primed, 0);
    check("rst_data_out", data_out, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_buf_rst", buf_rst, 1);
    check("rst_buf_en", buf_en, 0);
    rst = 1'b1;
  endtask

  initial begin
    bit ok;
    logic signed [DW-1:0] r;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; data_in = '0;

    // Fill the window with 1600s, then drain it with -1600s
    do_reset();
    for (int i = 0; i < 16; i++) begin send_sample(24'sd1600); get_output(0); end
    check("buf_en_count_16", n_buf_en, 16);
    for (int i = 0; i < 16; i++) begin send_sample(-24'sd1600); get_output(0); end
    check("buf_en_count_32", n_buf_en, n_accept);

    // Backpressure with the next sample waiting upstream
    send_sample(24'sd800);
    @(negedge clk);
    in_valid = 1'b1; data_in = 24'sd400; out_ready = 1'b0;
    wait_out_valid(ok);
    check("bp_out_valid_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_data_out", data_out, $signed(exp_q[0]));
      check("bp_in_ready", in_ready, 0);
      check("bp_buf_en", buf_en, 0);
      @(negedge clk); #1;
    end
    get_output(0);
    send_sample(24'sd400);
    get_output(1);
    check("bp_buf_en_count", n_buf_en, n_accept);

    // Partial fill then flush
    for (int i = 0; i < 8; i++) begin send_sample(24'sd1000); get_output(0); end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; data_in = 24'sd5;
    #1 check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_buf_rst_on", buf_rst, 1);
    @(negedge clk);
    check("flush_buf_rst_off", buf_rst, 0);
    check("flush_primed", primed, 0);
    check("flush_no_accept", n_buf_en, n_accept);
    model_clear();
    send_sample(24'sd1600); get_output(0);

    // Reset while holding an output
    send_sample(24'sd3200);
    wait_out_valid(ok);
    check("rst_mid_out_seen", ok, 1);
    rst = 1'b0;
    #1 check("rst_mid_buf_rst", buf_rst, 1);
    check("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    rst = 1'b1;
    model_clear();
    send_sample(24'sd160); get_output(0);

    // Floor toward -infinity
    do_reset();
    send_sample(-24'sd1); get_output(0);
    for (int i = 0; i < 16; i++) begin send_sample(24'sd0); get_output(0); end

    // Flush dropping a pending output
    send_sample(24'sd480);
    wait_out_valid(ok);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_drop_out_valid", out_valid, 0);
    model_clear();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 40; i++) begin
      r = DW'($urandom);
      send_sample(r);
      get_output($urandom_range(0, 3));
    end
    check("rand_buf_en_count", n_buf_en, n_accept);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
